// File: rtl/a2arb_pkg.sv
// Shared types and helpers for the Apple II bus read-data arbiter.
// Card vectors are widened to MAX_CARDS so the helpers serve any card count.
package a2arb_pkg;

  localparam int MAX_CARDS = 32;
  localparam int IDX_W     = 5;

  typedef logic [MAX_CARDS-1:0] card_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    GRANTED,
    RELEASED
  } arb_state_t;

  function automatic card_vec_t prio_onehot(
    input card_vec_t vec
  );
    return vec & (~vec + card_vec_t'(1));
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_idx(
    input card_vec_t oh
  );
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_CARDS; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_data_arbiter_sat_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
// Generic so other debug counters can reuse it.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/bus_data_arbiter.sv
// Per-bus-cycle read-data owner arbitration with a locked grant,
// contention counting and a registered, masked combined IRQ.
module bus_data_arbiter
  import a2arb_pkg::*;
#(
  parameter int NUM_CARDS          = 4,
  parameter int CONFLICT_CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cycle_end_i,
  input  logic [NUM_CARDS-1:0]          rd_en_i,
  input  logic [NUM_CARDS*8-1:0]        data_i,
  input  logic [NUM_CARDS-1:0]          irq_n_i,
  input  logic [NUM_CARDS-1:0]          irq_mask_i,
  output logic                          data_out_en_o,
  output logic [7:0]                    data_out_o,
  output logic [NUM_CARDS-1:0]          grant_o,
  output logic                          conflict_o,
  output logic [CONFLICT_CNT_WIDTH-1:0] conflict_count_o,
  output logic                          irq_n_o
);

  localparam int IDXW =
    (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1;

  arb_state_t state_q, state_nxt;

  logic [7:0]           lane [NUM_CARDS];
  logic [NUM_CARDS-1:0] winner_oh;
  logic [IDXW-1:0]      win_idx;
  logic [IDXW-1:0]      own_idx;
  logic                 owner_req;
  logic                 any_req;

  logic [NUM_CARDS-1:0] grant_nxt;
  logic                 en_nxt;
  logic [7:0]           data_nxt;
  logic                 conflict_nxt;
  logic                 flag_q, flag_nxt;

  for (genvar n = 0; n < NUM_CARDS; n++) begin : g_lane
    assign lane[n] = data_i[8*n +: 8];
  end

  assign winner_oh =
    NUM_CARDS'(prio_onehot(card_vec_t'(rd_en_i)));
  assign win_idx =
    IDXW'(onehot_to_idx(card_vec_t'(winner_oh)));
  assign own_idx =
    IDXW'(onehot_to_idx(card_vec_t'(grant_o)));
  assign owner_req = |(rd_en_i & grant_o);
  assign any_req   = |rd_en_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Bus cycle end dominates everything, including a fresh request.
  always_comb begin
    state_nxt = state_q;
    if (cycle_end_i) begin
      state_nxt = IDLE;
    end else begin
      unique case (state_q)
        IDLE:     if (any_req) state_nxt = GRANTED;
        GRANTED:  if (!owner_req) state_nxt = RELEASED;
        RELEASED: state_nxt = RELEASED;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    grant_nxt    = grant_o;
    en_nxt       = data_out_en_o;
    data_nxt     = data_out_o;
    conflict_nxt = 1'b0;
    flag_nxt     = flag_q;
    if (cycle_end_i) begin
      grant_nxt = '0;
      en_nxt    = 1'b0;
      flag_nxt  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_nxt = winner_oh;
            en_nxt    = 1'b1;
            data_nxt  = lane[win_idx];
            if (|(rd_en_i & ~winner_oh)) begin
              conflict_nxt = 1'b1;
              flag_nxt     = 1'b1;
            end
          end
        end
        GRANTED: begin
          data_nxt = lane[own_idx];
          if (!owner_req) en_nxt = 1'b0;
          // One contention pulse per bus cycle at most.
          if (!flag_q && |(rd_en_i & ~grant_o)) begin
            conflict_nxt = 1'b1;
            flag_nxt     = 1'b1;
          end
        end
        RELEASED: en_nxt = 1'b0;
        default: begin
          grant_nxt = '0;
          en_nxt    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_o       <= '0;
      data_out_en_o <= 1'b0;
      data_out_o    <= 8'h00;
      conflict_o    <= 1'b0;
      flag_q        <= 1'b0;
      irq_n_o       <= 1'b1;
    end else begin
      grant_o       <= grant_nxt;
      data_out_en_o <= en_nxt;
      data_out_o    <= data_nxt;
      conflict_o    <= conflict_nxt;
      flag_q        <= flag_nxt;
      irq_n_o       <= &(irq_n_i | ~irq_mask_i);
    end
  end

  sat_counter #(
    .WIDTH (CONFLICT_CNT_WIDTH)
  ) u_conflict_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (conflict_nxt),
    .count (conflict_count_o)
  );

endmodule

// File: tb/tb_bus_data_arbiter.sv
// Directed bench for bus_data_arbiter, narrow counter to reach saturation.
// Inputs change 1ns after posedge; outputs sampled 1ns after posedge.
module tb_bus_data_arbiter;

  localparam int NC = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cycle_end_i;
  logic [NC-1:0] rd_en_i;
  logic [31:0]   data_i;
  logic [NC-1:0] irq_n_i;
  logic [NC-1:0] irq_mask_i;
  logic          data_out_en_o;
  logic [7:0]    data_out_o;
  logic [NC-1:0] grant_o;
  logic          conflict_o;
  logic [CW-1:0] conflict_count_o;
  logic          irq_n_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_data_arbiter #(
    .NUM_CARDS          (NC),
    .CONFLICT_CNT_WIDTH (CW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cycle_end_i      (cycle_end_i),
    .rd_en_i          (rd_en_i),
    .data_i           (data_i),
    .irq_n_i          (irq_n_i),
    .irq_mask_i       (irq_mask_i),
    .data_out_en_o    (data_out_en_o),
    .data_out_o       (data_out_o),
    .grant_o          (grant_o),
    .conflict_o       (conflict_o),
    .conflict_count_o (conflict_count_o),
    .irq_n_o          (irq_n_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic end_cycle();
    cycle_end_i = 1'b1;
    rd_en_i     = '0;
    step();
    cycle_end_i = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    cycle_end_i = 1'b0;
    rd_en_i     = '0;
    data_i      = '0;
    irq_n_i     = 4'b1111;
    irq_mask_i  = 4'b1111;
    step();
    step();
    reset = 1'b0;
    #2;
    n_checks++;
    if (data_out_en_o !== 1'b0 || data_out_o !== 8'h00 ||
        grant_o !== 4'b0000 || conflict_o !== 1'b0 ||
        conflict_count_o !== 4'h0 || irq_n_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: en=%b data=%h grant=%b conf=%b cnt=%h irq=%b, want 0 00 0000 0 0 1",
               data_out_en_o, data_out_o, grant_o, conflict_o, conflict_count_o, irq_n_o);
    end
    step();
  endtask

  task automatic test_single();
    rd_en_i = 4'b0100;
    data_i  = 32'h00A5_0000;
    step();
    n_checks++;
    if (grant_o !== 4'b0100 || data_out_en_o !== 1'b1 ||
        data_out_o !== 8'hA5 || conflict_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_grant: grant=%b en=%b data=%h conf=%b, want 0100 1 a5 0",
               grant_o, data_out_en_o, data_out_o, conflict_o);
    end
    data_i = 32'h005A_0000;
    step();
    n_checks++;
    if (data_out_o !== 8'h5A) begin
      n_fail++;
      $display("FAIL single_track: data=%h want 5a", data_out_o);
    end
    cycle_end_i = 1'b1;
    step();
    n_checks++;
    if (grant_o !== 4'b0000 || data_out_en_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_cycle_end: grant=%b en=%b, want 0000 0",
               grant_o, data_out_en_o);
    end
    cycle_end_i = 1'b0;
    rd_en_i     = '0;
    step();
  endtask

  task automatic test_simultaneous();
    rd_en_i = 4'b0110;
    data_i  = 32'h0011_3C00;
    step();
    n_checks++;
    if (grant_o !== 4'b0010 || conflict_o !== 1'b1 ||
        conflict_count_o !== 4'h1 || data_out_o !== 8'h3C) begin
      n_fail++;
      $display("FAIL simul_grant: grant=%b conf=%b cnt=%h data=%h, want 0010 1 1 3c",
               grant_o, conflict_o, conflict_count_o, data_out_o);
    end
    step();
    n_checks++;
    if (conflict_o !== 1'b0 || conflict_count_o !== 4'h1) begin
      n_fail++;
      $display("FAIL simul_once: conf=%b cnt=%h, want 0 1",
               conflict_o, conflict_count_o);
    end
    end_cycle();
  endtask

  task automatic test_no_preempt();
    rd_en_i = 4'b1000;
    data_i  = 32'hC300_0000;
    step();
    n_checks++;
    if (grant_o !== 4'b1000 || conflict_o !== 1'b0) begin
      n_fail++;
      $display("FAIL preempt_grant: grant=%b conf=%b, want 1000 0",
               grant_o, conflict_o);
    end
    rd_en_i = 4'b1001;
    step();
    n_checks++;
    if (grant_o !== 4'b1000 || conflict_o !== 1'b1 ||
        conflict_count_o !== 4'h2) begin
      n_fail++;
      $display("FAIL preempt_late: grant=%b conf=%b cnt=%h, want 1000 1 2",
               grant_o, conflict_o, conflict_count_o);
    end
    step();
    rd_en_i = 4'b1011;
    step();
    n_checks++;
    if (grant_o !== 4'b1000 || conflict_o !== 1'b0 ||
        conflict_count_o !== 4'h2 || data_out_o !== 8'hC3) begin
      n_fail++;
      $display("FAIL preempt_second: grant=%b conf=%b cnt=%h data=%h, want 1000 0 2 c3",
               grant_o, conflict_o, conflict_count_o, data_out_o);
    end
    end_cycle();
  endtask

  task automatic test_release();
    rd_en_i = 4'b0001;
    data_i  = 32'h0000_0077;
    step();
    n_checks++;
    if (grant_o !== 4'b0001 || data_out_en_o !== 1'b1 ||
        data_out_o !== 8'h77) begin
      n_fail++;
      $display("FAIL rel_grant: grant=%b en=%b data=%h, want 0001 1 77",
               grant_o, data_out_en_o, data_out_o);
    end
    rd_en_i = 4'b0000;
    step();
    n_checks++;
    if (data_out_en_o !== 1'b0 || grant_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL rel_drop: en=%b grant=%b, want 0 0001",
               data_out_en_o, grant_o);
    end
    data_i = 32'h0000_0088;
    step();
    n_checks++;
    if (data_out_o !== 8'h77) begin
      n_fail++;
      $display("FAIL rel_hold: data=%h want 77", data_out_o);
    end
    rd_en_i = 4'b0001;
    step();
    n_checks++;
    if (data_out_en_o !== 1'b0 || grant_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL rel_no_regrant: en=%b grant=%b, want 0 0001",
               data_out_en_o, grant_o);
    end
    cycle_end_i = 1'b1;
    step();
    n_checks++;
    if (grant_o !== 4'b0000 || data_out_en_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rel_cycle_end: grant=%b en=%b, want 0000 0",
               grant_o, data_out_en_o);
    end
    cycle_end_i = 1'b0;
    step();
    n_checks++;
    if (grant_o !== 4'b0001 || data_out_en_o !== 1'b1 ||
        data_out_o !== 8'h88) begin
      n_fail++;
      $display("FAIL rel_regrant: grant=%b en=%b data=%h, want 0001 1 88",
               grant_o, data_out_en_o, data_out_o);
    end
    end_cycle();
  endtask

  task automatic test_irq();
    irq_n_i    = 4'b1101;
    irq_mask_i = 4'b1111;
    step();
    n_checks++;
    if (irq_n_o !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_assert: irq_n=%b want 0", irq_n_o);
    end
    irq_mask_i = 4'b1101;
    step();
    n_checks++;
    if (irq_n_o !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_masked: irq_n=%b want 1", irq_n_o);
    end
    irq_n_i    = 4'b0000;
    irq_mask_i = 4'b0000;
    step();
    n_checks++;
    if (irq_n_o !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_all_masked: irq_n=%b want 1", irq_n_o);
    end
    irq_n_i    = 4'b1111;
    irq_mask_i = 4'b1111;
  endtask

  task automatic test_saturation();
    int exp_cnt;
    exp_cnt = 2;
    for (int i = 0; i < 20; i++) begin
      rd_en_i = 4'b0011;
      step();
      exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
      n_checks++;
      if (conflict_o !== 1'b1 || conflict_count_o !== CW'(exp_cnt)) begin
        n_fail++;
        $display("FAIL sat_iter%0d: conf=%b cnt=%h, want 1 %h",
                 i, conflict_o, conflict_count_o, CW'(exp_cnt));
      end
      end_cycle();
    end
    n_checks++;
    if (conflict_count_o !== 4'hF) begin
      n_fail++;
      $display("FAIL sat_final: cnt=%h want f", conflict_count_o);
    end
  endtask

  task automatic test_reset_mid();
    rd_en_i = 4'b0001;
    data_i  = 32'h0000_00E1;
    irq_n_i = 4'b1110;
    step();
    n_checks++;
    if (grant_o !== 4'b0001 || irq_n_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_pre: grant=%b irq_n=%b, want 0001 0",
               grant_o, irq_n_o);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (data_out_en_o !== 1'b0 || data_out_o !== 8'h00 ||
        grant_o !== 4'b0000 || conflict_o !== 1'b0 ||
        conflict_count_o !== 4'h0 || irq_n_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_async: en=%b data=%h grant=%b conf=%b cnt=%h irq=%b, want 0 00 0000 0 0 1",
               data_out_en_o, data_out_o, grant_o, conflict_o, conflict_count_o, irq_n_o);
    end
    step();
    reset = 1'b0;
    #2;
    n_checks++;
    if (grant_o !== 4'b0000 || data_out_en_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release_hold: grant=%b en=%b, want 0000 0",
               grant_o, data_out_en_o);
    end
    step();
    n_checks++;
    if (grant_o !== 4'b0001 || data_out_en_o !== 1'b1 ||
        data_out_o !== 8'hE1 || irq_n_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_regrant: grant=%b en=%b data=%h irq=%b, want 0001 1 e1 0",
               grant_o, data_out_en_o, data_out_o, irq_n_o);
    end
    end_cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_no_preempt();
    test_release();
    test_irq();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_data_arbiter.md
Name: bus_data_arbiter

Overview:
- Arbitrates Apple II bus read-data ownership between slot cards (SuperSprite, Mockingboard, SuperSerial, future cards).
- Replaces the combinational rd_en OR / priority mux feeding apple_bus data_out_en/data_out.
- Grants one card per Apple bus cycle, locks the grant until the cycle ends, and counts contention events for debug.
- Also registers and masks the combined IRQ line.

Parameters:
- NUM_CARDS, 4, number of requesting cards; index 0 has the highest priority.
- CONFLICT_CNT_WIDTH, 16, width of the saturating conflict counter.

Ports:
- clk  input  1  logic clock (54 MHz domain).
- reset  input  1  asynchronous, active-high reset.
- cycle_end_i  input  1  one-clk pulse marking the end of an Apple bus cycle (phi1_posedge in the clk domain).
- rd_en_i  input  NUM_CARDS  per-card read request; bit n belongs to card n.
- data_i  input  NUM_CARDS*8  per-card read data; card n occupies bits [8n+7:8n].
- irq_n_i  input  NUM_CARDS  per-card IRQ, active-low.
- irq_mask_i  input  NUM_CARDS  1 = card IRQ enabled.
- data_out_en_o  output  1  drive bus data.
- data_out_o  output  8  data to drive.
- grant_o  output  NUM_CARDS  one-hot current owner.
- conflict_o  output  1  one-clk pulse on a contention event.
- conflict_count_o  output  CONFLICT_CNT_WIDTH  saturating contention count.
- irq_n_o  output  1  registered combined IRQ, active-low.

Behaviour:
- Reset: state IDLE; data_out_en_o=0; data_out_o=8'h00; grant_o=0; conflict_o=0; conflict_count_o=0; irq_n_o=1. Reset is asynchronous assert; outputs update only on the next clk edge after deassertion.
- Winner: the lowest index n with rd_en_i[n]=1.
- State IDLE:
  - If any rd_en_i=1 and cycle_end_i=0, go to GRANTED.
  - grant_o <= one-hot(winner); data_out_en_o <= 1; data_out_o <= data_i[winner].
  - If the popcount of rd_en_i is >1, pulse conflict_o.
- State GRANTED:
  - data_out_o <= data_i[granted] every clk, so data tracks the owner with 1-clk latency.
  - A higher-priority request arriving later does NOT preempt the owner.
  - The first clk in which any non-owner rd_en_i is 1 pulses conflict_o; this happens at most once per bus cycle, including the grant-time conflict.
  - If the owner drops rd_en, go to RELEASED next clk: data_out_en_o <= 0, grant_o held.
- State RELEASED:
  - No re-grant within the same bus cycle.
  - data_out_en_o=0; data_out_o holds its last value.
- cycle_end_i in any state:
  - Next state is IDLE; grant_o <= 0; data_out_en_o <= 0; the per-cycle conflict flag clears.
  - cycle_end_i has priority over new requests in the same clk, so there is no grant on that clk.
- Latency: request to data_out_en_o is 1 clk; owner release to data_out_en_o=0 is 1 clk.
- conflict_count_o increments on every conflict_o pulse and saturates at all-ones; it does not wrap.
- irq_n_o <= &(irq_n_i | ~irq_mask_i), registered with 1 clk latency. All cards masked gives irq_n_o=1.
- Invariants: grant_o is always zero or one-hot. data_out_en_o=1 implies grant_o≠0.

Decomposition:
- Shared package a2arb_pkg:
  - typedef arb_state_t enum {IDLE, GRANTED, RELEASED}.
  - function prio_onehot(vec): lowest-set-bit one-hot.
  - function onehot_to_idx.
- Sub-module sat_counter (parameter WIDTH; ports inc, count) for conflict_count_o; it is reusable by other debug counters.

Test Plan:
- Single request: rd_en_i=4'b0100, data_i card2=8'hA5 -> next clk grant_o=4'b0100, data_out_en_o=1, data_out_o=8'hA5, conflict_o=0. cycle_end_i pulse -> next clk grant_o=0, data_out_en_o=0.
- Simultaneous: rd_en_i=4'b0110 from IDLE -> grant_o=4'b0010; conflict_o pulses once; conflict_count_o=1.
- No preemption: card3 granted, then card0 requests mid-cycle -> grant_o stays 4'b1000; conflict_o pulses once. A second late request in the same cycle -> no further pulse.
- Release then re-request: the owner drops rd_en -> data_out_en_o=0 after 1 clk. The owner re-raises before cycle_end_i -> stays RELEASED. After cycle_end_i -> granted again.
- Saturation/reset: CONFLICT_CNT_WIDTH=4, force 20 conflicts -> count holds 4'hF. Assert reset mid-GRANTED -> all outputs go to reset values immediately, with irq_n_o=1.
- IRQ: irq_n_i=4'b1101 with irq_mask_i=4'b1111 -> irq_n_o=0 after 1 clk. Then irq_mask_i=4'b1101 -> irq_n_o=1 after 1 clk.
